// File: rtl/clock_pkg.sv
// Shared types and helpers for the clock divider bank.
// Provides the per-channel state type, the minimum legal period and
// eff_cfg(), which turns raw DIV/HIGH fields into the effective period,
// high time and low time (P/H/L). Fields are carried at 32 bits so any
// CNT_W up to 31 can use the same helper; callers narrow the result.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } chan_state_t;

  localparam int unsigned MIN_PERIOD = 2;
  localparam int unsigned CFG_W      = 32;

  typedef struct packed {
    logic [CFG_W-1:0] p;
    logic [CFG_W-1:0] h;
    logic [CFG_W-1:0] l;
  } eff_cfg_t;

  // P = max(DIV, 2); H = min(HIGH, P-1); L = P - H, so L is never zero.
  function automatic eff_cfg_t eff_cfg(input logic [CFG_W-1:0] div,
                                       input logic [CFG_W-1:0] high);
    eff_cfg_t c;
    c.p = (div < CFG_W'(MIN_PERIOD)) ? CFG_W'(MIN_PERIOD) : div;
    c.h = (high > c.p - CFG_W'(1)) ? c.p - CFG_W'(1) : high;
    c.l = c.p - c.h;
    return c;
  endfunction

endpackage

// File: rtl/clock_div_channel.sv
// One divider channel: run/stop FSM, phase counter, config latch and
// registered CLK_OUT/TICK/RUNNING.
// Ports:
//   CLOCK, nRESET      system clock, async active-low reset
//   ENABLE             run request for this channel
//   DIV, HIGH          raw period / high-time fields (latched at period start)
//   RESYNC             shared phase-realign pulse
//   CLK_OUT            divided clock level (low phase first, then high phase)
//   TICK               one-cycle pulse in the first high cycle of CLK_OUT
//   RUNNING            high in RUN or STOPPING
module clock_div_channel
  import clock_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLOCK,
  input  logic             nRESET,
  input  logic             ENABLE,
  input  logic [CNT_W-1:0] DIV,
  input  logic [CNT_W-1:0] HIGH,
  input  logic             RESYNC,
  output logic             CLK_OUT,
  output logic             TICK,
  output logic             RUNNING
);

  chan_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] p_q, h_q, l_q;
  logic [CNT_W-1:0] p_n, h_n, l_n;
  logic             latch_c, wrap_c, run_n, clk_n, tick_n;
  eff_cfg_t         cfg_c;
  logic             unused_cfg_hi;

  // Effective config of the current DIV/HIGH inputs; values fit CNT_W.
  assign cfg_c         = eff_cfg(CFG_W'(DIV), CFG_W'(HIGH));
  assign unused_cfg_hi = ^{cfg_c.p[CFG_W-1:CNT_W], cfg_c.h[CFG_W-1:CNT_W],
                           cfg_c.l[CFG_W-1:CNT_W]};

  assign wrap_c = (cnt == p_q - CNT_W'(1));

  // Next state, next count, config latch and next output levels.
  // A wrap or RESYNC ends the period: keep going only if still enabled.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    latch_c = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (ENABLE) begin
          state_n = RUN;
          latch_c = 1'b1;
        end
      end
      RUN, STOPPING: begin
        if (wrap_c || RESYNC) begin
          cnt_n = '0;
          if (ENABLE) begin
            state_n = RUN;
            latch_c = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n   = cnt + CNT_W'(1);
          state_n = ENABLE ? RUN : STOPPING;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    p_n    = latch_c ? CNT_W'(cfg_c.p) : p_q;
    h_n    = latch_c ? CNT_W'(cfg_c.h) : h_q;
    l_n    = latch_c ? CNT_W'(cfg_c.l) : l_q;
    run_n  = (state_n != IDLE);
    clk_n  = run_n && (cnt_n >= l_n);
    tick_n = run_n && (cnt_n == l_n) && (h_n != '0);
  end

  // State register.
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) state <= IDLE;
    else         state <= state_n;
  end

  // Counter, latched config and registered outputs.
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      cnt     <= '0;
      p_q     <= '0;
      h_q     <= '0;
      l_q     <= '0;
      CLK_OUT <= 1'b0;
      TICK    <= 1'b0;
      RUNNING <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      p_q     <= p_n;
      h_q     <= h_n;
      l_q     <= l_n;
      CLK_OUT <= clk_n;
      TICK    <= tick_n;
      RUNNING <= run_n;
    end
  end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of CHANNELS independent programmable clock dividers sharing one
// system clock, reset and RESYNC pulse.
// Ports:
//   CLOCK, nRESET   system clock, async active-low reset
//   ENABLE          per-channel run request
//   DIV, HIGH       per-channel period / high time, channel i at [i*CNT_W +: CNT_W]
//   RESYNC          realigns the phase of all running channels
//   CLK_OUT         per-channel divided clock (registered)
//   TICK            per-channel first-high-cycle strobe
//   RUNNING         per-channel active indication
module clock_divider_bank #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                      CLOCK,
  input  logic                      nRESET,
  input  logic [CHANNELS-1:0]       ENABLE,
  input  logic [CHANNELS*CNT_W-1:0] DIV,
  input  logic [CHANNELS*CNT_W-1:0] HIGH,
  input  logic                      RESYNC,
  output logic [CHANNELS-1:0]       CLK_OUT,
  output logic [CHANNELS-1:0]       TICK,
  output logic [CHANNELS-1:0]       RUNNING
);

  // One channel per slice of the packed config buses.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    clock_div_channel #(
      .CNT_W(CNT_W)
    ) u_chan (
      .CLOCK  (CLOCK),
      .nRESET (nRESET),
      .ENABLE (ENABLE[i]),
      .DIV    (DIV[i*CNT_W +: CNT_W]),
      .HIGH   (HIGH[i*CNT_W +: CNT_W]),
      .RESYNC (RESYNC),
      .CLK_OUT(CLK_OUT[i]),
      .TICK   (TICK[i]),
      .RUNNING(RUNNING[i])
    );
  end

endmodule
